// File: rtl/fetch_controller_pkg.sv
// Shared definitions for the fetch controller slice.
//   fc_state_t : FSM state encodings (3 is unused and recovers to IDLE)
//   seq_cmd_t  : per-cycle command from the FSM to the pc sequencer
package fetch_controller_pkg;

  localparam int DEF_ADDR_W  = 12;
  localparam int DEF_INSTR_W = 19;
  localparam int CNT_W       = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fc_state_t;

  // restart  : load RESET_PC as the pending fetch
  // redirect : load redirect_target as the pending fetch (zero bubble)
  // advance  : consumer took the current word, move on to pc
  typedef struct packed {
    logic restart;
    logic redirect;
    logic advance;
  } seq_cmd_t;

endpackage

// File: rtl/fetch_controller_pc_sequencer.sv
// Fetch address sequencer: owns pc (next address to fetch) and pending_pc
// (address whose data is on the memory read port), and picks the address
// driven to instruction memory this cycle.
//   clock, reset     : clock, synchronous active-high reset
//   cmd              : restart / redirect / advance from the FSM
//   redirect_target  : new fetch address for a redirect
//   mem_address      : combinational memory address
//   pending_pc       : address of the word currently on mem_instruction
module pc_sequencer
  import fetch_controller_pkg::*;
#(
  parameter int          ADDR_W   = DEF_ADDR_W,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  seq_cmd_t          cmd,
  input  logic [ADDR_W-1:0] redirect_target,
  output logic [ADDR_W-1:0] mem_address,
  output logic [ADDR_W-1:0] pending_pc
);

  localparam logic [ADDR_W-1:0] RST_PC = ADDR_W'(RESET_PC);
  localparam logic [ADDR_W-1:0] ONE    = ADDR_W'(1);

  logic [ADDR_W-1:0] pc;

  // The address issued now is the one whose data arrives next cycle, so it
  // always matches what pending_pc becomes at the coming edge.
  always_comb begin
    mem_address = pending_pc;
    if (!cmd.restart) begin
      if (cmd.redirect)     mem_address = redirect_target;
      else if (cmd.advance) mem_address = pc;
    end
  end

  // Address arithmetic wraps naturally at 2^ADDR_W.
  always_ff @(posedge clock) begin
    if (reset || cmd.restart) begin
      pending_pc <= RST_PC;
      pc         <= RST_PC + ONE;
    end else if (cmd.redirect) begin
      pending_pc <= redirect_target;
      pc         <= redirect_target + ONE;
    end else if (cmd.advance) begin
      pending_pc <= pc;
      pc         <= pc + ONE;
    end
  end

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch controller. Streams instructions from a registered
// (1-cycle latency) instruction memory to a valid/ready consumer, with
// start/halt control, zero-bubble redirects and an accepted-instruction count.
//   clock, reset             : clock, synchronous active-high reset
//   start, halt_req          : run control
//   redirect_valid/target    : taken branch/jump
//   out_ready                : consumer handshake
//   mem_instruction          : memory read data (word at last mem_address)
//   mem_address              : memory address (combinational)
//   out_valid/instruction/pc : presented instruction and its address
//   state_out                : FSM state encoding
//   fetch_count              : accepted instructions, saturating
module fetch_controller
  import fetch_controller_pkg::*;
#(
  parameter int          ADDR_W   = DEF_ADDR_W,
  parameter int          INSTR_W  = DEF_INSTR_W,
  parameter int unsigned RESET_PC = 0
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               halt_req,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_target,
  input  logic               out_ready,
  input  logic [INSTR_W-1:0] mem_instruction,
  output logic [ADDR_W-1:0]  mem_address,
  output logic               out_valid,
  output logic [INSTR_W-1:0] out_instruction,
  output logic [ADDR_W-1:0]  out_pc,
  output logic [1:0]         state_out,
  output logic [CNT_W-1:0]   fetch_count
);

  fc_state_t state, state_nxt;
  seq_cmd_t  cmd;
  logic      count_en;

  pc_sequencer #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_seq (
    .clock           (clock),
    .reset           (reset),
    .cmd             (cmd),
    .redirect_target (redirect_target),
    .mem_address     (mem_address),
    .pending_pc      (out_pc)
  );

  assign out_instruction = mem_instruction;
  assign state_out       = state;

  always_ff @(posedge clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cmd       = '0;
    out_valid = 1'b0;
    count_en  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt   = ST_RUN;
          cmd.restart = 1'b1;
        end
      end
      ST_RUN: begin
        out_valid = 1'b1;
        // Redirect beats halt: the handshake in a redirect cycle is dropped.
        if (redirect_valid) begin
          cmd.redirect = 1'b1;
        end else begin
          cmd.advance = out_ready;
          count_en    = out_ready;
          if (halt_req) state_nxt = ST_HALT;
        end
      end
      ST_HALT: begin
        // Keep re-reading pending_pc so the word is ready on resume.
        cmd.redirect = redirect_valid;
        if (start) state_nxt = ST_RUN;
      end
      default: begin
        // Unused encoding: go back to IDLE with a clean fetch address.
        state_nxt   = ST_IDLE;
        cmd.restart = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset)                           fetch_count <= '0;
    else if (count_en && !(&fetch_count)) fetch_count <= fetch_count + CNT_W'(1);
  end

endmodule

// File: tb/tb_fetch_controller.sv
module tb_fetch_controller;

  localparam int AW = 12;
  localparam int IW = 19;
  localparam int DEPTH = 1 << AW;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0, halt_req = 1'b0, redirect_valid = 1'b0, out_ready = 1'b0;
  logic [AW-1:0] redirect_target = '0;
  logic [IW-1:0] mem_instruction = '0;
  logic [AW-1:0] mem_address, out_pc;
  logic          out_valid;
  logic [IW-1:0] out_instruction;
  logic [1:0]    state_out;
  logic [15:0]   fetch_count;

  fetch_controller dut (
    .clock(clock), .reset(reset), .start(start), .halt_req(halt_req),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .out_ready(out_ready), .mem_instruction(mem_instruction),
    .mem_address(mem_address), .out_valid(out_valid),
    .out_instruction(out_instruction), .out_pc(out_pc),
    .state_out(state_out), .fetch_count(fetch_count)
  );

  always #5 clock = ~clock;

  // Registered instruction memory the block is paired with.
  logic [IW-1:0] mem [DEPTH];
  always @(posedge clock) mem_instruction <= mem[mem_address];

  int vectors = 0;
  int miscompares = 0;

  // Reference model: state as 0=idle,1=run,2=halt, addresses as plain ints.
  bit model_known = 0;
  int m_st, m_pend, m_pc, m_cnt;

  // One clock cycle: drive inputs mid-cycle, check against the model,
  // then advance the model by the rules for this cycle's inputs.
  task automatic cyc(input bit st, input bit hr, input bit rv, input int rt,
                     input bit rdy, input bit rs);
    int exp_addr;
    @(negedge clock);
    start = st; halt_req = hr; redirect_valid = rv;
    redirect_target = AW'(rt); out_ready = rdy; reset = rs;
    #1;
    if (model_known) begin
      if (m_st == 1)      exp_addr = rv ? rt : (rdy ? m_pc : m_pend);
      else if (m_st == 2) exp_addr = rv ? rt : m_pend;
      else                exp_addr = m_pend;
      vectors += 6;
      if (mem_address !== AW'(exp_addr)) begin
        miscompares++; $display("FAIL addr: got %0d want %0d", mem_address, exp_addr);
      end
      if (out_valid !== (m_st == 1)) begin
        miscompares++; $display("FAIL valid: got %0b want %0b", out_valid, m_st == 1);
      end
      if (out_pc !== AW'(m_pend)) begin
        miscompares++; $display("FAIL out_pc: got %0d want %0d", out_pc, m_pend);
      end
      if (m_st == 1 && out_instruction !== mem[m_pend]) begin
        miscompares++; $display("FAIL instr: got %h want %h", out_instruction, mem[m_pend]);
      end
      if (fetch_count !== 16'(m_cnt)) begin
        miscompares++; $display("FAIL count: got %0d want %0d", fetch_count, m_cnt);
      end
      if (state_out !== 2'(m_st)) begin
        miscompares++; $display("FAIL state: got %0d want %0d", state_out, m_st);
      end
    end
    if (rs) begin
      model_known = 1; m_st = 0; m_pend = 0; m_pc = 1; m_cnt = 0;
    end else if (model_known) begin
      case (m_st)
        0: if (st) begin m_st = 1; m_pend = 0; m_pc = 1; end
        1: begin
          if (rv) begin
            m_pend = rt; m_pc = (rt + 1) % DEPTH;
          end else begin
            if (rdy) begin
              m_pend = m_pc; m_pc = (m_pc + 1) % DEPTH;
              if (m_cnt < 65535) m_cnt++;
            end
            if (hr) m_st = 2;
          end
        end
        default: begin
          if (rv) begin m_pend = rt; m_pc = (rt + 1) % DEPTH; end
          if (st) m_st = 1;
        end
      endcase
    end
  endtask

  task automatic restart();
    cyc(0, 0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 1, 1, 55, 1, 0);
    vectors++;
    if (state_out !== 2'd0 || out_valid !== 1'b0 || mem_address !== 12'd0 || fetch_count !== 16'd0) begin
      miscompares++;
      $display("FAIL reset: state %0d valid %0b addr %0d cnt %0d want 0 0 0 0",
               state_out, out_valid, mem_address, fetch_count);
    end
  endtask

  task automatic test_sequential();
    restart();
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 0, 0, 1, 0);
      vectors++;
      if (out_pc !== AW'(i) || out_instruction !== mem[i]) begin
        miscompares++;
        $display("FAIL seq[%0d]: pc %0d instr %h want pc %0d instr %h", i, out_pc, out_instruction, i, mem[i]);
      end
    end
    cyc(0, 0, 0, 0, 0, 0);
    vectors++;
    if (fetch_count !== 16'd4) begin
      miscompares++; $display("FAIL seq_count: got %0d want 4", fetch_count);
    end
  endtask

  task automatic test_stall();
    restart();
    cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0, 0, 0);
      vectors++;
      if (out_pc !== 12'd2 || out_instruction !== mem[2] || mem_address !== 12'd2 || fetch_count !== 16'd2) begin
        miscompares++;
        $display("FAIL stall[%0d]: pc %0d instr %h addr %0d cnt %0d want 2 %h 2 2",
                 i, out_pc, out_instruction, mem_address, fetch_count, mem[2]);
      end
    end
  endtask

  task automatic test_redirect();
    restart();
    cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 0, 1, 100, 1, 0);
    cyc(0, 0, 0, 0, 1, 0);
    vectors++;
    if (out_valid !== 1'b1 || out_pc !== 12'd100 || out_instruction !== mem[100] || fetch_count !== 16'd1) begin
      miscompares++;
      $display("FAIL redirect: valid %0b pc %0d instr %h cnt %0d want 1 100 %h 1",
               out_valid, out_pc, out_instruction, fetch_count, mem[100]);
    end
  endtask

  task automatic test_wrap();
    restart();
    cyc(0, 0, 1, 4095, 0, 0);
    cyc(0, 0, 0, 0, 1, 0);
    vectors++;
    if (out_pc !== 12'd4095) begin
      miscompares++; $display("FAIL wrap_a: got %0d want 4095", out_pc);
    end
    cyc(0, 0, 0, 0, 1, 0);
    vectors++;
    if (out_pc !== 12'd0 || out_instruction !== mem[0]) begin
      miscompares++; $display("FAIL wrap_b: got %0d want 0", out_pc);
    end
    cyc(0, 0, 0, 0, 0, 0);
    vectors++;
    if (fetch_count !== 16'd2) begin
      miscompares++; $display("FAIL wrap_count: got %0d want 2", fetch_count);
    end
  endtask

  task automatic test_halt_resume();
    restart();
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 1, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0, 1, 0);
      vectors++;
      if (state_out !== 2'd2 || out_valid !== 1'b0) begin
        miscompares++; $display("FAIL halt: state %0d valid %0b want 2 0", state_out, out_valid);
      end
    end
    cyc(1, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    vectors++;
    if (out_valid !== 1'b1 || out_pc !== 12'd6 || out_instruction !== mem[6]) begin
      miscompares++; $display("FAIL resume: valid %0b pc %0d want 1 6", out_valid, out_pc);
    end
  endtask

  task automatic test_reset_in_stall();
    restart();
    for (int i = 0; i < 7; i++) cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0);
    vectors++;
    if (state_out !== 2'd0 || out_valid !== 1'b0 || mem_address !== 12'd0 || fetch_count !== 16'd0) begin
      miscompares++;
      $display("FAIL reset_stall: state %0d valid %0b addr %0d cnt %0d want 0 0 0 0",
               state_out, out_valid, mem_address, fetch_count);
    end
  endtask

  task automatic test_random();
    restart();
    for (int i = 0; i < 4000; i++) begin
      bit st, hr, rv, rdy, rs;
      int rt;
      st  = ($urandom_range(99) < 20);
      hr  = ($urandom_range(99) < 5);
      rv  = ($urandom_range(99) < 10);
      rdy = ($urandom_range(99) < 70);
      rs  = ($urandom_range(999) < 5);
      rt  = $urandom_range(1) ? int'($urandom_range(DEPTH - 1)) : int'($urandom_range(DEPTH - 1, DEPTH - 6));
      cyc(st, hr, rv, rt, rdy, rs);
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = IW'($urandom);
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_wrap();
    test_halt_resume();
    test_reset_in_stall();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fetch_controller.md
FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 Parameter ADDR_W, default 12, instruction-memory address width.
REQ-002 Parameter INSTR_W, default 19, instruction word width.
REQ-003 Parameter RESET_PC, default 0, first fetch address after reset.
REQ-004 clock  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  begin fetching from IDLE, or resume from HALT.
REQ-007 halt_req  input  1  stop presenting instructions after the current cycle.
REQ-008 redirect_valid  input  1  branch/jump taken this cycle.
REQ-009 redirect_target  input  ADDR_W  new fetch address when redirect_valid=1.
REQ-010 out_ready  input  1  consumer accepts out_instruction this cycle.
REQ-011 mem_instruction  input  INSTR_W  registered read data from instruction memory, one cycle after mem_address.
REQ-012 mem_address  output  ADDR_W  address to instruction memory, combinational from state and inputs.
REQ-013 out_valid  output  1  out_instruction/out_pc valid.
REQ-014 out_instruction  output  INSTR_W  equals mem_instruction (pass-through).
REQ-015 out_pc  output  ADDR_W  address of out_instruction (pending_pc register).
REQ-016 state_out  output  2  current FSM state encoding.
REQ-017 fetch_count  output  16  number of accepted instructions, saturating.

Function
REQ-018 Registers: state, pc (next address to fetch), pending_pc (address whose data is on mem_instruction), fetch_count.
REQ-019 States: IDLE=0, RUN=1, HALT=2; encoding 3 unused, recovers to IDLE on next edge.
REQ-020 fire = out_valid AND out_ready; out_valid = 1 exactly when state==RUN.
REQ-021 Invariant in RUN: mem_instruction holds the word at pending_pc (memory latency exactly 1 cycle).
REQ-022 IDLE: mem_address=pending_pc; start -> RUN, pending_pc<=RESET_PC, pc<=RESET_PC+1; redirect_valid and halt_req ignored.
REQ-023 RUN, priority redirect > halt > normal.
REQ-024 RUN with redirect_valid: mem_address=redirect_target, pending_pc<=target, pc<=target+1, out_valid still 1 but fire does not count; target word valid next cycle (zero bubble).
REQ-025 RUN normal with fire: mem_address=pc, pending_pc<=pc, pc<=pc+1, fetch_count++.
REQ-026 RUN without fire (stall): mem_address=pending_pc, pc and pending_pc hold; out_instruction stable across stall.
REQ-027 RUN with halt_req (no redirect): same datapath update as REQ-025/026 this cycle, then state<=HALT.
REQ-028 HALT: out_valid=0, mem_address=pending_pc; start -> RUN, pending word presented next cycle; redirect_valid updates pending_pc/pc as REQ-024 and stays HALT.
REQ-029 pc arithmetic modulo 2^ADDR_W: 4095+1 wraps to 0, no flag.
REQ-030 fetch_count saturates at 65535; counts only fires not coincident with redirect.
REQ-031 start and halt_req together in HALT: start wins (resume); in RUN: halt wins.

Reset
REQ-032 On reset: state=IDLE, pending_pc=RESET_PC, pc=RESET_PC+1, fetch_count=0; hence out_valid=0, mem_address=RESET_PC next cycle.
REQ-033 Reset mid-RUN or mid-stall discards the in-flight word; no output handshake completes in the reset cycle.

Structure
REQ-034 Shared package holds state encodings (IDLE/RUN/HALT) and default widths ADDR_W=12, INSTR_W=19.
REQ-035 One sub-module, pc_sequencer, SHALL contain pc/pending_pc and the mem_address mux; FSM and counter stay in fetch_controller.
REQ-036 No memory inside this block; pairs with the existing 4096x19 registered instruction memory.

Verification
REQ-037 Reset, start, out_ready=1 for 4 cycles -> out_pc 0,1,2,3 with matching memory words, fetch_count=4.
REQ-038 In RUN at out_pc=2, out_ready=0 for 3 cycles -> out_pc=2 and out_instruction held, mem_address=2, fetch_count unchanged.
REQ-039 redirect_valid with target=100 at out_pc=1 -> next cycle out_valid=1, out_pc=100, no bubble, redirect cycle not counted.
REQ-040 Redirect to 4095, accept 2 -> out_pc 4095 then 0.
REQ-041 halt_req at out_pc=5 with fire -> HALT, out_valid=0; start 4 cycles later -> next cycle out_pc=6.
REQ-042 Reset asserted during stall at out_pc=7 -> next cycle state=IDLE, out_valid=0, mem_address=0, fetch_count=0.
